// File: rtl/gpio_bus_arbiter_if.sv
// Bundle of host-side and device-side signals around the GPIO bus arbiter.
// slave is the arbiter's view; master is the view of the hosts and the GPIO device around it.
interface gpio_bus_arbiter_if #(
  parameter int NumHosts = 2
);
  logic [NumHosts-1:0]      host_req_i;
  logic [NumHosts*32-1:0]   host_addr_i;
  logic [NumHosts-1:0]      host_we_i;
  logic [NumHosts*4-1:0]    host_be_i;
  logic [NumHosts*32-1:0]   host_wdata_i;
  logic [NumHosts-1:0]      host_lock_i;
  logic [NumHosts-1:0]      host_gnt_o;
  logic [NumHosts-1:0]      host_rvalid_o;
  logic [NumHosts*32-1:0]   host_rdata_o;
  logic                     device_req_o;
  logic [31:0]              device_addr_o;
  logic                     device_we_o;
  logic [3:0]               device_be_o;
  logic [31:0]              device_wdata_o;
  logic                     device_rvalid_i;
  logic [31:0]              device_rdata_i;

  modport slave (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i, host_lock_i,
    input  device_rvalid_i, device_rdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o,
    output device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o
  );

  modport master (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i, host_lock_i,
    output device_rvalid_i, device_rdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o,
    input  device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o
  );
endinterface

// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter sharing the GPIO device port between NumHosts requesters.
// Optional bus locking is compiled in with GPIO_ARB_LOCK_EN.
module gpio_bus_arbiter #(
  parameter int NumHosts = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  gpio_bus_arbiter_if.slave   bus
);

  localparam int HostIdxW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
  localparam logic [HostIdxW-1:0] LastHost = HostIdxW'(NumHosts - 1);

  logic [HostIdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [HostIdxW-1:0] winner;
  logic [HostIdxW-1:0] resp_host_q;
  logic                resp_pend_q;
  logic                gnt_any;
  logic                lock_active;
  logic [NumHosts-1:0] eligible;
  logic [NumHosts-1:0] gnt_vec;
  logic [NumHosts-1:0] rvalid_vec;

  logic [31:0] addr_arr  [NumHosts];
  logic [31:0] wdata_arr [NumHosts];
  logic [3:0]  be_arr    [NumHosts];
  logic        we_arr    [NumHosts];

`ifdef GPIO_ARB_LOCK_EN
  logic                lock_valid_q, lock_valid_d;
  logic [HostIdxW-1:0] lock_own_q, lock_own_d;

  // The lock stays in force only while its owner keeps host_lock_i high,
  // so a dropped lock frees the bus in the very same cycle.
  assign lock_active = lock_valid_q & bus.host_lock_i[lock_own_q];

  always_comb begin
    eligible = bus.host_req_i;
    if (lock_active) begin
      eligible = '0;
      eligible[lock_own_q] = bus.host_req_i[lock_own_q];
    end
  end

  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_own_d   = lock_own_q;
    if (gnt_any && bus.host_lock_i[winner]) begin
      lock_valid_d = 1'b1;
      lock_own_d   = winner;
    end else if (lock_valid_q && !bus.host_lock_i[lock_own_q]) begin
      lock_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_valid_q <= 1'b0;
      lock_own_q   <= '0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_own_q   <= lock_own_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^bus.host_lock_i;
  assign lock_active = 1'b0;
  assign eligible    = bus.host_req_i;
`endif

  always_comb begin
    for (int h = 0; h < NumHosts; h++) begin
      addr_arr[h]  = bus.host_addr_i[32*h +: 32];
      wdata_arr[h] = bus.host_wdata_i[32*h +: 32];
      be_arr[h]    = bus.host_be_i[4*h +: 4];
      we_arr[h]    = bus.host_we_i[h];
    end
  end

  // First eligible host found scanning upward from rr_ptr_q, wrapping at NumHosts.
  always_comb begin
    int cand;
    winner  = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int off = 0; off < NumHosts; off++) begin
      cand = int'(rr_ptr_q) + off;
      if (cand >= NumHosts) begin
        cand = cand - NumHosts;
      end
      if (!gnt_any && eligible[cand]) begin
        gnt_any = 1'b1;
        winner  = cand[HostIdxW-1:0];
      end
    end
  end

  always_comb begin
    gnt_vec = '0;
    if (gnt_any) begin
      gnt_vec[winner] = 1'b1;
    end
  end

  // Device request follows the grant; in the default build that equals |host_req_i,
  // and with locking it keeps a locked-out host from reaching the device.
  always_comb begin
    bus.device_req_o   = gnt_any;
    bus.device_addr_o  = '0;
    bus.device_we_o    = 1'b0;
    bus.device_be_o    = '0;
    bus.device_wdata_o = '0;
    if (gnt_any) begin
      bus.device_addr_o  = addr_arr[winner];
      bus.device_we_o    = we_arr[winner];
      bus.device_be_o    = be_arr[winner];
      bus.device_wdata_o = wdata_arr[winner];
    end
  end

  assign bus.host_gnt_o = gnt_vec;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any && !lock_active) begin
      rr_ptr_d = (winner == LastHost) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      resp_pend_q <= 1'b0;
      resp_host_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      resp_pend_q <= gnt_any;
      resp_host_q <= winner;
    end
  end

  // A device response with nothing pending is dropped.
  always_comb begin
    rvalid_vec = '0;
    if (bus.device_rvalid_i && resp_pend_q) begin
      rvalid_vec[resp_host_q] = 1'b1;
    end
  end

  assign bus.host_rvalid_o = rvalid_vec;
  assign bus.host_rdata_o  = {NumHosts{bus.device_rdata_i}};

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed and randomized checks of gpio_bus_arbiter against a transaction-level model.
module tb_gpio_bus_arbiter;
  localparam int NH = 2;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  gpio_bus_arbiter_if #(.NumHosts(NH)) bus ();

  gpio_bus_arbiter #(.NumHosts(NH)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int passed = 0;
  int total  = 0;

  logic [31:0] t_addr  [NH];
  logic [31:0] t_wdata [NH];
  logic [3:0]  t_be    [NH];
  logic        t_we    [NH];

  // model: next host favoured, lock owner (-1 none), outstanding response owner
  int m_ptr, m_lock, m_pend_host;
  bit m_pend;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_lock = -1; m_pend = 0; m_pend_host = 0;
  endtask

  task automatic drive(input logic [NH-1:0] req, input logic [NH-1:0] lk,
                       input logic rv, input logic [31:0] rdata);
    bus.host_req_i  = req;
    bus.host_lock_i = lk;
    for (int h = 0; h < NH; h++) begin
      bus.host_addr_i[32*h +: 32]  = t_addr[h];
      bus.host_wdata_i[32*h +: 32] = t_wdata[h];
      bus.host_be_i[4*h +: 4]      = t_be[h];
      bus.host_we_i[h]             = t_we[h];
    end
    bus.device_rvalid_i = rv;
    bus.device_rdata_i  = rdata;
  endtask

  // rv_mode: 0 = no response, 1 = forced response, 2 = device answers what was issued last cycle
  task automatic run_cycle(input logic [NH-1:0] req, input logic [NH-1:0] lk, input int rv_mode,
                           input logic [31:0] rdata, output int win);
    logic rv;
    logic lock_act;
    logic [NH-1:0] exp_gnt, exp_rv;
    @(negedge clk_i);
    rv = (rv_mode == 2) ? m_pend : rv_mode[0];
    drive(req, lk, rv, rdata);
    #1;
    lock_act = 1'b0;
`ifdef GPIO_ARB_LOCK_EN
    lock_act = (m_lock >= 0) && lk[m_lock];
`endif
    win = -1;
    if (lock_act) begin
      if (req[m_lock]) win = m_lock;
    end else begin
      for (int o = 0; o < NH; o++) begin
        int h;
        h = (m_ptr + o) % NH;
        if (win < 0 && req[h]) win = h;
      end
    end
    exp_gnt = '0;
    if (win >= 0) exp_gnt[win] = 1'b1;
    exp_rv = '0;
    if (rv && m_pend) exp_rv[m_pend_host] = 1'b1;

    chk("gnt", bus.host_gnt_o, exp_gnt);
    chk("dev_req", bus.device_req_o, win >= 0);
    chk("dev_addr", bus.device_addr_o, (win >= 0) ? t_addr[win] : 32'h0);
    chk("dev_wdata", bus.device_wdata_o, (win >= 0) ? t_wdata[win] : 32'h0);
    chk("dev_be", bus.device_be_o, (win >= 0) ? t_be[win] : 4'h0);
    chk("dev_we", bus.device_we_o, (win >= 0) ? t_we[win] : 1'b0);
    chk("rvalid", bus.host_rvalid_o, exp_rv);
    chk("rdata", bus.host_rdata_o, {NH{rdata}});

    if (win >= 0 && !lock_act) m_ptr = (win + 1) % NH;
`ifdef GPIO_ARB_LOCK_EN
    if (win >= 0 && lk[win]) m_lock = win;
    else if (m_lock >= 0 && !lk[m_lock]) m_lock = -1;
`endif
    m_pend = (win >= 0);
    if (win >= 0) m_pend_host = win;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    drive('0, '0, 1'b0, 32'h0);
    @(negedge clk_i);
    model_reset();
    rst_ni = 1'b1;
  endtask

  initial begin
    int w;
    logic [NH-1:0] p, t_lock, req;
    int wt [NH];
    logic [1:0] seq2 [4];
    logic [1:0] seq6 [4];

    for (int h = 0; h < NH; h++) begin
      t_addr[h] = '0; t_wdata[h] = '0; t_be[h] = '0; t_we[h] = 1'b0; wt[h] = 0;
    end
    model_reset();

    // reset state, including a stray device response during reset
    drive('0, '0, 1'b1, 32'h1234_5678);
    #2;
    chk("rst_gnt", bus.host_gnt_o, 2'b00);
    chk("rst_rvalid", bus.host_rvalid_o, 2'b00);
    chk("rst_dev_req", bus.device_req_o, 1'b0);
    chk("rst_dev_addr", bus.device_addr_o, 32'h0);
    chk("rst_dev_wdata", bus.device_wdata_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // 1: single host write then read
    t_addr[1] = 32'h0; t_we[1] = 1'b1; t_be[1] = 4'b0011; t_wdata[1] = 32'h0000_A5A5;
    run_cycle(2'b10, 2'b00, 2, 32'h0, w);
    chk("t1_gnt_wr", bus.host_gnt_o, 2'b10);
    chk("t1_wdata", bus.device_wdata_o, 32'h0000_A5A5);
    t_addr[1] = 32'h4; t_we[1] = 1'b0; t_be[1] = 4'hF; t_wdata[1] = 32'h0;
    run_cycle(2'b10, 2'b00, 2, 32'h0, w);
    chk("t1_gnt_rd", bus.host_gnt_o, 2'b10);
    chk("t1_rvalid_wr", bus.host_rvalid_o, 2'b10);
    run_cycle(2'b00, 2'b00, 2, 32'h0000_003C, w);
    chk("t1_rvalid_rd", bus.host_rvalid_o, 2'b10);
    chk("t1_rdata", bus.host_rdata_o[63:32], 32'h0000_003C);

    // 2: contention from reset
    do_reset();
    seq2 = '{2'b01, 2'b10, 2'b01, 2'b10};
    t_addr[0] = 32'h10; t_addr[1] = 32'h14;
    for (int i = 0; i < 4; i++) begin
      run_cycle(2'b11, 2'b00, 2, $urandom, w);
      chk("t2_gnt_seq", bus.host_gnt_o, seq2[i]);
      if (i > 0) chk("t2_rvalid_seq", bus.host_rvalid_o, seq2[i-1]);
    end
    run_cycle(2'b00, 2'b00, 2, $urandom, w);
    chk("t2_rvalid_last", bus.host_rvalid_o, seq2[3]);

    // 3: spurious response
    do_reset();
    run_cycle(2'b00, 2'b00, 1, 32'hDEAD_BEEF, w);
    chk("t3_spurious", bus.host_rvalid_o, 2'b00);

    // 4: reset while a response is in flight
    run_cycle(2'b01, 2'b00, 2, 32'h0, w);
    @(negedge clk_i);
    drive('0, '0, 1'b1, 32'h55);
    #1;
    chk("t4_rvalid_before", bus.host_rvalid_o, 2'b01);
    rst_ni = 1'b0;
    #1;
    chk("t4_rvalid_rst", bus.host_rvalid_o, 2'b00);
    @(negedge clk_i);
    model_reset();
    rst_ni = 1'b1;
    run_cycle(2'b11, 2'b00, 2, 32'h0, w);
    chk("t4_first_gnt", bus.host_gnt_o, 2'b01);

    // 5: host1 held while host0 is served
    do_reset();
    t_addr[0] = 32'h8; t_addr[1] = 32'h4;
    run_cycle(2'b11, 2'b00, 2, 32'h0, w);
    chk("t5_gnt0", bus.host_gnt_o, 2'b01);
    run_cycle(2'b10, 2'b00, 2, 32'h0, w);
    chk("t5_gnt1", bus.host_gnt_o, 2'b10);
    chk("t5_addr", bus.device_addr_o, 32'h4);

    // 6: host0 locks for three cycles while host1 keeps requesting
    do_reset();
`ifdef GPIO_ARB_LOCK_EN
    seq6 = '{2'b01, 2'b01, 2'b01, 2'b10};
`else
    seq6 = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    for (int i = 0; i < 4; i++) begin
      run_cycle(2'b11, (i < 3) ? 2'b01 : 2'b00, 2, $urandom, w);
      chk("t6_gnt_seq", bus.host_gnt_o, seq6[i]);
    end

    // randomized traffic: waiting hosts hold request and payload
    do_reset();
    p = '0; t_lock = '0;
    for (int c = 0; c < 400; c++) begin
      for (int h = 0; h < NH; h++) begin
        if (!p[h] && $urandom_range(0, 2) != 0) begin
          p[h]       = 1'b1;
          t_addr[h]  = $urandom;
          t_wdata[h] = $urandom;
          t_be[h]    = 4'($urandom);
          t_we[h]    = 1'($urandom);
          t_lock[h]  = ($urandom_range(0, 3) == 0);
        end
      end
      req = p;
      run_cycle(req, req & t_lock, 2, $urandom, w);
      for (int h = 0; h < NH; h++) begin
        if (req[h] && h != w) wt[h]++;
        else wt[h] = 0;
`ifndef GPIO_ARB_LOCK_EN
        chk("fairness", wt[h] <= NH - 1, 1'b1);
`endif
      end
      if (w >= 0) p[w] = 1'b0;
    end
    run_cycle('0, '0, 2, $urandom, w);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
